// File: rtl/cell_hist.sv
// Per-cell orientation histogram: classifies each {magnitude, tan} sample into
// one of 9 orientation bins and emits the per-bin magnitude sums once per cell.
module cell_hist #(
  parameter int MAG_W    = 13,
  parameter int TAN_W    = 20,
  parameter int CELL_PIX = 64,
  parameter int BIN_W    = MAG_W + $clog2(CELL_PIX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [MAG_W-1:0]     magnitude,
  input  logic [TAN_W-1:0]     tan,
  output logic [9*BIN_W-1:0]   hist,
  output logic                 o_valid
);

  localparam int CNT_W = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CELL_PIX - 1);

  // tan(20/40/60/80 deg) in Q4.16, and their negations
  localparam logic signed [TAN_W-1:0] T20 = TAN_W'(23853);
  localparam logic signed [TAN_W-1:0] T40 = TAN_W'(54991);
  localparam logic signed [TAN_W-1:0] T60 = TAN_W'(113512);
  localparam logic signed [TAN_W-1:0] T80 = TAN_W'(371673);
  localparam logic signed [TAN_W-1:0] N20 = TAN_W'(-23853);
  localparam logic signed [TAN_W-1:0] N40 = TAN_W'(-54991);
  localparam logic signed [TAN_W-1:0] N60 = TAN_W'(-113512);
  localparam logic signed [TAN_W-1:0] N80 = TAN_W'(-371673);

  logic signed [TAN_W-1:0] tan_s;
  logic [3:0]              bin_c;

  logic [CNT_W-1:0] cnt;
  logic             s1_valid, s1_last, s1_first;
  logic [MAG_W-1:0] s1_mag;
  logic [3:0]       s1_bin;
  logic [BIN_W-1:0] acc [9];
  logic             s2_done;

  assign tan_s = tan;

  // Strict less-than puts exact threshold values into the higher-angle bin
  always_comb begin
    bin_c = 4'd0;
    if (!tan_s[TAN_W-1]) begin
      if      (tan_s < T20) bin_c = 4'd0;
      else if (tan_s < T40) bin_c = 4'd1;
      else if (tan_s < T60) bin_c = 4'd2;
      else if (tan_s < T80) bin_c = 4'd3;
      else                  bin_c = 4'd4;
    end else begin
      if      (tan_s < N80) bin_c = 4'd4;
      else if (tan_s < N60) bin_c = 4'd5;
      else if (tan_s < N40) bin_c = 4'd6;
      else if (tan_s < N20) bin_c = 4'd7;
      else                  bin_c = 4'd8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_mag   <= '0;
      s1_bin   <= '0;
      for (int unsigned k = 0; k < 9; k++) acc[k] <= '0;
      s2_done  <= 1'b0;
      hist     <= '0;
      o_valid  <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        cnt      <= cnt + CNT_W'(1);
        s1_mag   <= magnitude;
        s1_bin   <= bin_c;
        s1_last  <= (cnt == LAST_CNT);
        s1_first <= (cnt == '0);
      end

      // First sample of a cell overwrites all bins, so cells need no clear cycle
      if (s1_valid) begin
        for (int unsigned k = 0; k < 9; k++)
          acc[k] <= (s1_first ? '0 : acc[k]) +
                    ((s1_bin == 4'(k)) ? BIN_W'(s1_mag) : '0);
      end

      s2_done <= s1_valid & s1_last;
      o_valid <= s2_done;
      if (s2_done) begin
        for (int unsigned k = 0; k < 9; k++)
          hist[k*BIN_W +: BIN_W] <= acc[k];
      end
    end
  end

endmodule

// File: tb/tb_cell_hist.sv
// Directed testbench for cell_hist: per-scenario tasks with hand-computed sums.
module tb_cell_hist;

  localparam int MAG_W = 13;
  localparam int TAN_W = 20;
  localparam int CELL_PIX = 64;
  localparam int BIN_W = 19;
  localparam int HW = 9 * BIN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic [MAG_W-1:0] magnitude;
  logic [TAN_W-1:0] tan;
  logic [HW-1:0]    hist;
  logic             o_valid;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_accept = 0;
  logic [HW-1:0] pulse_hist [$];
  int            pulse_cyc  [$];

  cell_hist #(.MAG_W(MAG_W), .TAN_W(TAN_W), .CELL_PIX(CELL_PIX), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .magnitude(magnitude),
    .tan(tan), .hist(hist), .o_valid(o_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      pulse_hist.push_back(hist);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input logic [MAG_W-1:0] m, input logic signed [TAN_W-1:0] t);
    @(negedge clk);
    i_valid = v; magnitude = m; tan = t;
    if (v) last_accept = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; magnitude = '0; tan = '0;
    repeat (3) @(negedge clk);
    checks++; if (hist !== '0) $display("FAIL reset_hist got %h exp 0", hist); else passes++;
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_ovalid got %b exp 0", o_valid); else passes++;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_continuous;
    int n0; logic [HW-1:0] exp_h;
    n0 = pulse_hist.size();
    for (int i = 0; i < CELL_PIX; i++) drive(1'b1, 13'd16, 20'sd0);
    idle(5);
    exp_h = '0; exp_h[0*BIN_W +: BIN_W] = 19'd1024;
    checks++; if (pulse_hist.size() != n0 + 1) $display("FAIL cont_pulses got %0d exp %0d", pulse_hist.size() - n0, 1); else passes++;
    if (pulse_hist.size() == n0 + 1) begin
      checks++; if (pulse_cyc[n0] != last_accept + 2) $display("FAIL cont_latency got %0d exp %0d", pulse_cyc[n0], last_accept + 2); else passes++;
      checks++; if (pulse_hist[n0] !== exp_h) $display("FAIL cont_hist got %h exp %h", pulse_hist[n0], exp_h); else passes++;
    end
  endtask

  task automatic test_threshold;
    int n0; logic [HW-1:0] exp_h;
    logic signed [TAN_W-1:0] tv [7];
    tv = '{20'sd23852, 20'sd23853, 20'sd371673, -20'sd371674, -20'sd371673, -20'sd23853, -20'sd1};
    n0 = pulse_hist.size();
    for (int i = 0; i < 7; i++) drive(1'b1, 13'd1, tv[i]);
    for (int i = 7; i < CELL_PIX; i++) drive(1'b1, 13'd0, 20'sd0);
    idle(5);
    exp_h = '0;
    exp_h[0*BIN_W +: BIN_W] = 19'd1;
    exp_h[1*BIN_W +: BIN_W] = 19'd1;
    exp_h[4*BIN_W +: BIN_W] = 19'd2;
    exp_h[5*BIN_W +: BIN_W] = 19'd1;
    exp_h[8*BIN_W +: BIN_W] = 19'd2;
    checks++; if (pulse_hist.size() != n0 + 1) $display("FAIL thr_pulses got %0d exp %0d", pulse_hist.size() - n0, 1); else passes++;
    if (pulse_hist.size() == n0 + 1) begin
      checks++; if (pulse_hist[n0] !== exp_h) $display("FAIL thr_hist got %h exp %h", pulse_hist[n0], exp_h); else passes++;
    end
  endtask

  task automatic test_saturation;
    int n0; logic [HW-1:0] exp_h;
    n0 = pulse_hist.size();
    for (int i = 0; i < CELL_PIX; i++) drive(1'b1, 13'd8191, 20'sh7FFFF);
    idle(5);
    exp_h = '0; exp_h[4*BIN_W +: BIN_W] = 19'd524224;
    checks++; if (pulse_hist.size() != n0 + 1) $display("FAIL max_pulses got %0d exp %0d", pulse_hist.size() - n0, 1); else passes++;
    if (pulse_hist.size() == n0 + 1) begin
      checks++; if (pulse_hist[n0] !== exp_h) $display("FAIL max_hist got %h exp %h", pulse_hist[n0], exp_h); else passes++;
    end
    n0 = pulse_hist.size();
    for (int i = 0; i < CELL_PIX; i++) drive(1'b1, 13'd1, 20'sh80000);
    idle(5);
    exp_h = '0; exp_h[4*BIN_W +: BIN_W] = 19'd64;
    checks++; if (pulse_hist.size() != n0 + 1) $display("FAIL negsat_pulses got %0d exp %0d", pulse_hist.size() - n0, 1); else passes++;
    if (pulse_hist.size() == n0 + 1) begin
      checks++; if (pulse_hist[n0] !== exp_h) $display("FAIL negsat_hist got %h exp %h", pulse_hist[n0], exp_h); else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int n0, a_last; logic [HW-1:0] exp_a, exp_b;
    n0 = pulse_hist.size();
    for (int i = 0; i < CELL_PIX; i++) drive(1'b1, 13'd1, 20'sd65536);
    a_last = last_accept;
    for (int i = 0; i < CELL_PIX; i++) drive(1'b1, 13'd2, -20'sd65536);
    idle(5);
    exp_a = '0; exp_a[2*BIN_W +: BIN_W] = 19'd64;
    exp_b = '0; exp_b[6*BIN_W +: BIN_W] = 19'd128;
    checks++; if (pulse_hist.size() != n0 + 2) $display("FAIL b2b_pulses got %0d exp %0d", pulse_hist.size() - n0, 2); else passes++;
    if (pulse_hist.size() == n0 + 2) begin
      checks++; if (pulse_cyc[n0] != a_last + 2) $display("FAIL b2b_latency got %0d exp %0d", pulse_cyc[n0], a_last + 2); else passes++;
      checks++; if (pulse_cyc[n0+1] - pulse_cyc[n0] != CELL_PIX) $display("FAIL b2b_spacing got %0d exp %0d", pulse_cyc[n0+1] - pulse_cyc[n0], CELL_PIX); else passes++;
      checks++; if (pulse_hist[n0] !== exp_a) $display("FAIL b2b_hist_a got %h exp %h", pulse_hist[n0], exp_a); else passes++;
      checks++; if (pulse_hist[n0+1] !== exp_b) $display("FAIL b2b_hist_b got %h exp %h", pulse_hist[n0+1], exp_b); else passes++;
    end
  endtask

  task automatic test_gapped;
    int n0; logic [HW-1:0] exp_h;
    n0 = pulse_hist.size();
    for (int i = 0; i < CELL_PIX; i++) begin
      drive(1'b1, 13'd16, 20'sd0);
      drive(1'b0, 13'd100, 20'sd65536);
    end
    idle(5);
    exp_h = '0; exp_h[0*BIN_W +: BIN_W] = 19'd1024;
    checks++; if (pulse_hist.size() != n0 + 1) $display("FAIL gap_pulses got %0d exp %0d", pulse_hist.size() - n0, 1); else passes++;
    if (pulse_hist.size() == n0 + 1) begin
      checks++; if (pulse_cyc[n0] != last_accept + 2) $display("FAIL gap_latency got %0d exp %0d", pulse_cyc[n0], last_accept + 2); else passes++;
      checks++; if (pulse_hist[n0] !== exp_h) $display("FAIL gap_hist got %h exp %h", pulse_hist[n0], exp_h); else passes++;
    end
  endtask

  task automatic test_reset_mid;
    int n0; logic [HW-1:0] exp_h;
    n0 = pulse_hist.size();
    for (int i = 0; i < 30; i++) drive(1'b1, 13'd5, 20'sd65536);
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (hist !== '0) $display("FAIL rstmid_hist got %h exp 0", hist); else passes++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rstmid_ovalid got %b exp 0", o_valid); else passes++;
    repeat (2) @(negedge clk);
    checks++; if (hist !== '0) $display("FAIL rstmid_hist_hold got %h exp 0", hist); else passes++;
    rst = 1'b0;
    for (int i = 0; i < CELL_PIX; i++) drive(1'b1, 13'd3, -20'sd1);
    idle(5);
    exp_h = '0; exp_h[8*BIN_W +: BIN_W] = 19'd192;
    checks++; if (pulse_hist.size() != n0 + 1) $display("FAIL rstmid_pulses got %0d exp %0d", pulse_hist.size() - n0, 1); else passes++;
    if (pulse_hist.size() == n0 + 1) begin
      checks++; if (pulse_cyc[n0] != last_accept + 2) $display("FAIL rstmid_latency got %0d exp %0d", pulse_cyc[n0], last_accept + 2); else passes++;
      checks++; if (pulse_hist[n0] !== exp_h) $display("FAIL rstmid_hist_out got %h exp %h", pulse_hist[n0], exp_h); else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_threshold;
    test_saturation;
    test_back_to_back;
    test_gapped;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
